// File: rtl/hssi_tg_mailbox_rsp.sv
// hssi_tg_mailbox_rsp
// Responder side of the HSSI traffic-controller mailbox. The host writes the
// ADDRESS / WRDATA / CMD dwords; each RD or WR command becomes exactly one
// Avalon-MM transaction on the traffic generator/monitor register port. Read
// returns are captured in RDDATA, and completion is reported through the
// ack bit of the CMD dword, which the host polls.
//
// Optional feature: define HSSI_MB_TIMEOUT_EN to enable a backend response
// timeout of TIMEOUT_CYCLES cycles. On expiry the request is dropped (even
// under waitrequest), a read returns 32'hFFFF_FFFF, and ack and err are set.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   csr_wr / csr_rd     mailbox dword write / read strobes
//   csr_sel             0 CMD, 1 ADDRESS, 2 RDDATA, 3 WRDATA
//   csr_wdata           host write data
//   csr_rdata(_vld)     registered read data, one cycle after csr_rd
//   ctrl_*              Avalon-MM host port toward the TG/TM registers
//
// CMD readback: [0] rd in flight, [1] wr in flight, [2] ack, [3] err.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no access outstanding, CMD writes accepted
// ISSUE    | ctrl_read/ctrl_write asserted until waitrequest drops
// WAIT_RD  | read accepted, waiting for readdatavalid
// DONE     | one cycle: set ack, clear in-flight bits

module hssi_tg_mailbox_rsp #(
    parameter int unsigned CTRL_ADDR_W    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   csr_wr,
    input  logic                   csr_rd,
    input  logic [1:0]             csr_sel,
    input  logic [31:0]            csr_wdata,
    output logic [31:0]            csr_rdata,
    output logic                   csr_rdata_vld,
    output logic [CTRL_ADDR_W-1:0] ctrl_addr,
    output logic                   ctrl_write,
    output logic                   ctrl_read,
    output logic [31:0]            ctrl_wdata,
    input  logic                   ctrl_waitrequest,
    input  logic [31:0]            ctrl_readdata,
    input  logic                   ctrl_readdatavalid
);

    if (CTRL_ADDR_W < 1 || CTRL_ADDR_W > 32) begin : g_bad_addr_w
        $error("CTRL_ADDR_W must be in 1..32");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    localparam logic [1:0]  SEL_CMD    = 2'd0;
    localparam logic [1:0]  SEL_ADDR   = 2'd1;
    localparam logic [1:0]  SEL_RDDATA = 2'd2;
    localparam logic [1:0]  SEL_WRDATA = 2'd3;

    localparam logic [31:0] MB_NOOP = 32'd0;
    localparam logic [31:0] MB_RD   = 32'd1;
    localparam logic [31:0] MB_WR   = 32'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic                   rd_fl_q, rd_fl_d;
    logic                   wr_fl_q, wr_fl_d;
    // Request copies taken at command accept so host ADDRESS/WRDATA writes
    // during ISSUE cannot disturb a stalled request.
    logic [CTRL_ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [31:0]            req_wdata_q, req_wdata_d;
    logic [31:0]            csr_rdata_q, csr_rdata_d;
    logic                   csr_rdata_vld_q;

    logic                   cmd_wr;
    logic                   req_en;
    logic                   abort;
    logic                   timeout;

    assign cmd_wr = csr_wr && (csr_sel == SEL_CMD);

`ifdef HSSI_MB_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero in IDLE, so it is zero on the first ISSUE cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_ISSUE || state_q == ST_WAIT_RD) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (state_q == ST_ISSUE || state_q == ST_WAIT_RD) &&
                     (cnt_q == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ack_d       = ack_q;
        err_d       = err_q;
        rd_fl_d     = rd_fl_q;
        wr_fl_d     = wr_fl_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_en      = 1'b0;
        abort       = 1'b0;

        if (csr_wr && csr_sel == SEL_ADDR) begin
            addr_d = csr_wdata;
        end
        if (csr_wr && csr_sel == SEL_WRDATA) begin
            wdata_d = csr_wdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_wr) begin
                    if (csr_wdata == MB_NOOP) begin
                        ack_d = 1'b0;
                        err_d = 1'b0;
                    end else if (csr_wdata == MB_RD || csr_wdata == MB_WR) begin
                        ack_d       = 1'b0;
                        err_d       = 1'b0;
                        rd_fl_d     = (csr_wdata == MB_RD);
                        wr_fl_d     = (csr_wdata == MB_WR);
                        req_addr_d  = addr_q[CTRL_ADDR_W-1:0];
                        req_wdata_d = wdata_q;
                        state_d     = ST_ISSUE;
                    end else begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                // The timeout deliberately drops the request even while
                // waitrequest is high; that is the recovery path.
                if (timeout) begin
                    abort = 1'b1;
                end else begin
                    req_en = 1'b1;
                    if (!ctrl_waitrequest) begin
                        state_d = rd_fl_q ? ST_WAIT_RD : ST_DONE;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (ctrl_readdatavalid) begin
                    rdata_d = ctrl_readdata;
                    state_d = ST_DONE;
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            ST_DONE: begin
                ack_d   = 1'b1;
                rd_fl_d = 1'b0;
                wr_fl_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            if (rd_fl_q) begin
                rdata_d = 32'hFFFF_FFFF;
            end
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rd_fl_d = 1'b0;
            wr_fl_d = 1'b0;
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        csr_rdata_d = csr_rdata_q;
        if (csr_rd) begin
            case (csr_sel)
                SEL_CMD:    csr_rdata_d = {28'd0, err_q, ack_q, wr_fl_q, rd_fl_q};
                SEL_ADDR:   csr_rdata_d = addr_q;
                SEL_RDDATA: csr_rdata_d = rdata_q;
                SEL_WRDATA: csr_rdata_d = wdata_q;
                default:    csr_rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= 32'd0;
            wdata_q         <= 32'd0;
            rdata_q         <= 32'd0;
            ack_q           <= 1'b0;
            err_q           <= 1'b0;
            rd_fl_q         <= 1'b0;
            wr_fl_q         <= 1'b0;
            req_addr_q      <= '0;
            req_wdata_q     <= 32'd0;
            csr_rdata_q     <= 32'd0;
            csr_rdata_vld_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            rdata_q         <= rdata_d;
            ack_q           <= ack_d;
            err_q           <= err_d;
            rd_fl_q         <= rd_fl_d;
            wr_fl_q         <= wr_fl_d;
            req_addr_q      <= req_addr_d;
            req_wdata_q     <= req_wdata_d;
            csr_rdata_q     <= csr_rdata_d;
            csr_rdata_vld_q <= csr_rd;
        end
    end

    assign ctrl_read     = req_en && rd_fl_q;
    assign ctrl_write    = req_en && wr_fl_q;
    assign ctrl_addr     = req_addr_q;
    assign ctrl_wdata    = req_wdata_q;
    assign csr_rdata     = csr_rdata_q;
    assign csr_rdata_vld = csr_rdata_vld_q;

endmodule
